// File: rtl/output_buffer_drain.sv
// rtl/output_buffer_drain.sv - accumulator result buffer with valid bits and a streaming drain port
// Optional build macro OUTBUF_SKIP_EMPTY_EN: drain scans past entries whose valid bit is clear.
module output_buffer_drain #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W:0]   drain_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_fresh,
    output logic              busy,
    output logic              done,
    output logic              overwrite_err
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W:0]   eff_count;
    logic              start_ok;
    logic              handshake;
    logic              advance;
    logic              last;
    logic              fwd;
    logic              ld_fresh;
    logic              ld_valid;
    logic              ld_fresh_out;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    assign eff_count = (drain_count > DEPTH_C) ? DEPTH_C : drain_count;
    assign start_ok  = (state == IDLE) && drain_start && (eff_count != '0);
    assign handshake = (state == SEND) && out_valid && out_ready;
    assign last      = (remain == (ADDR_W+1)'(1));

    // Next payload source; a same-cycle write to it is forwarded so it is never stale.
    assign ld_addr  = start_ok ? '0 : ptr + 1'b1;
    assign fwd      = wr_en && (wr_addr == ld_addr);
    assign ld_data  = fwd ? wr_data : mem[ld_addr];
    assign ld_fresh = fwd || valid[ld_addr];

`ifdef OUTBUF_SKIP_EMPTY_EN
    assign advance      = (state == SEND) && (out_ready || !out_valid);
    assign ld_valid     = ld_fresh;
    assign ld_fresh_out = 1'b1;
`else
    assign advance      = handshake;
    assign ld_valid     = 1'b1;
    assign ld_fresh_out = ld_fresh;
`endif

    assign busy = (state == SEND);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain_start) state_nxt = start_ok ? SEND : DONE;
            SEND:    if (advance && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid         <= '0;
            ptr           <= '0;
            remain        <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_addr      <= '0;
            out_fresh     <= 1'b0;
            overwrite_err <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr       <= '0;
                remain    <= eff_count;
                out_valid <= ld_valid;
                out_data  <= ld_data;
                out_addr  <= '0;
                out_fresh <= ld_fresh_out;
            end else if (advance) begin
                remain <= remain - 1'b1;
                if (last) begin
                    out_valid <= 1'b0;
                end else begin
                    ptr       <= ld_addr;
                    out_valid <= ld_valid;
                    out_data  <= ld_data;
                    out_addr  <= ld_addr;
                    out_fresh <= ld_fresh_out;
                end
            end
            // Clear-on-consume first so a same-cycle write to that entry wins.
            if (handshake) valid[ptr] <= 1'b0;
            if (wr_en) valid[wr_addr] <= 1'b1;
            if ((state == IDLE) && drain_start) overwrite_err <= 1'b0;
            if (wr_en && valid[wr_addr] && !(handshake && (wr_addr == ptr))) overwrite_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_buffer_drain.sv
// tb/tb_output_buffer_drain.sv - scoreboard bench for output_buffer_drain
module tb_output_buffer_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        drain_start = 1'b0;
    logic [4:0]  drain_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_fresh;
    logic        busy;
    logic        done;
    logic        overwrite_err;

    always #5 clk = ~clk;

    output_buffer_drain dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drain_start(drain_start), .drain_count(drain_count), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_fresh(out_fresh), .busy(busy), .done(done), .overwrite_err(overwrite_err)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        bit          known;
        bit          fresh;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    bit          ref_known [16];
    bit          ref_valid [16];
    bit          ref_err = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_hs = 0;
    bit          bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void model_push(input int count);
        int eff;
        eff = (count > 16) ? 16 : count;
        for (int a = 0; a < eff; a++) begin
`ifdef OUTBUF_SKIP_EMPTY_EN
            if (ref_valid[a]) exp_q.push_back('{4'(a), ref_mem[a], ref_known[a], 1'b1});
`else
            exp_q.push_back('{4'(a), ref_mem[a], ref_known[a], ref_valid[a]});
`endif
        end
    endfunction

    function automatic void model_commit(input int count);
        int eff;
        eff = (count > 16) ? 16 : count;
        for (int a = 0; a < eff; a++) ref_valid[a] = 1'b0;
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [36:0] cur;
        logic [36:0] held;
        bit          held_v;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (done) n_done++;
                cur = {out_addr, out_data, out_fresh};
                if (out_valid) begin
                    if (held_v) chk(cur == held, "payload_stable", 64'(cur), 64'(held));
                    if (out_ready) begin
                        held_v = 1'b0;
                        n_hs++;
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_payload", 64'(cur), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk((out_addr == e.addr) && (out_fresh == e.fresh) && (!e.known || (out_data == e.data)),
                                "payload", 64'(cur), 64'({e.addr, e.data, e.fresh}));
                        end
                    end else begin
                        held_v = 1'b1;
                        held = cur;
                    end
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (ref_valid[a]) ref_err = 1'b1;
        ref_mem[a] = d;
        ref_known[a] = 1'b1;
        ref_valid[a] = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk(overwrite_err == ref_err, "overwrite_err", 64'(overwrite_err), 64'(ref_err));
    endtask

    task automatic run_drain(input int count, input int rmode, input bit cw, input int cw_k,
                             input logic [3:0] cwa, input logic [31:0] cwd);
        int d0;
        int hs0;
        int nexp;
        bit got;
        bit first_v;
        d0 = n_done;
        hs0 = n_hs;
        nexp = exp_q.size();
        first_v = (nexp > 0) && (exp_q[0].addr == 4'd0);
        drain_start = 1'b1;
        drain_count = 5'(count);
        @(posedge clk); #1;
        drain_start = 1'b0;
        ref_err = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (rmode == 0)                out_ready = 1'b1;
            else if (rmode == 2 && k < 5)  out_ready = bp_pat[k];
            else if (rmode == 2)           out_ready = 1'b1;
            else                           out_ready = 1'($urandom_range(0, 1));
            if (cw && k == cw_k) begin
                wr_en = 1'b1;
                wr_addr = cwa;
                wr_data = cwd;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (k == 0) chk(out_valid == first_v, "first_valid", 64'(out_valid), 64'(first_v));
            if (done) got = 1'b1;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        out_ready = 1'b0;
        chk(got, "done_seen", 64'(got), 64'(1));
        chk(n_done - d0 == 1, "done_pulses", 64'(n_done - d0), 64'(1));
        chk(n_hs - hs0 == nexp, "handshakes", 64'(n_hs - hs0), 64'(nexp));
        chk(exp_q.size() == 0, "sb_drained", 64'(exp_q.size()), 64'(0));
        chk(!busy && !done && !out_valid, "idle_after", 64'({busy, done, out_valid}), 64'(0));
    endtask

    task automatic drain(input int count, input int rmode);
        model_push(count);
        run_drain(count, rmode, 1'b0, 0, 4'd0, 32'd0);
        model_commit(count);
        chk(overwrite_err == ref_err, "err_after_drain", 64'(overwrite_err), 64'(ref_err));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin : main
        int  d0;
        bit  found;
        int  nw;
        int  cnt;
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = '0;
            ref_known[a] = 1'b0;
            ref_valid[a] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({out_valid, busy, done, overwrite_err, out_fresh} == 5'b0, "reset_flags",
            64'({out_valid, busy, done, overwrite_err, out_fresh}), 64'(0));
        chk(out_data == 32'd0 && out_addr == 4'd0, "reset_payload", 64'({out_addr, out_data}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk({out_valid, busy, done} == 3'b0, "post_reset_idle", 64'({out_valid, busy, done}), 64'(0));

        for (int a = 0; a < 4; a++) do_write(4'(a), 32'hA0 + 32'(a));
        drain(4, 0);

        for (int a = 0; a < 3; a++) do_write(4'(a), 32'hB0 + 32'(a));
        drain(3, 2);

        do_write(4'd5, 32'h11);
        do_write(4'd5, 32'h22);
        drain(6, 0);

        // Forward into the next load while addr 1 is accepted.
        for (int a = 0; a < 4; a++) do_write(4'(a), 32'hC0 + 32'(a));
        exp_q.push_back('{4'd0, 32'hC0, 1'b1, 1'b1});
        exp_q.push_back('{4'd1, 32'hC1, 1'b1, 1'b1});
        exp_q.push_back('{4'd2, 32'hBEEF, 1'b1, 1'b1});
        exp_q.push_back('{4'd3, 32'hC3, 1'b1, 1'b1});
        run_drain(4, 0, 1'b1, 1, 4'd2, 32'hBEEF);
        ref_mem[2] = 32'hBEEF;
        model_commit(4);
        ref_err = 1'b1;
        chk(overwrite_err == ref_err, "err_fwd_write", 64'(overwrite_err), 64'(ref_err));

        // Write the entry being accepted: write wins, no error.
        for (int a = 0; a < 4; a++) do_write(4'(a), 32'hD0 + 32'(a));
        exp_q.push_back('{4'd0, 32'hD0, 1'b1, 1'b1});
        exp_q.push_back('{4'd1, 32'hD1, 1'b1, 1'b1});
        exp_q.push_back('{4'd2, 32'hD2, 1'b1, 1'b1});
        exp_q.push_back('{4'd3, 32'hD3, 1'b1, 1'b1});
        run_drain(4, 0, 1'b1, 1, 4'd1, 32'h1234);
        model_commit(4);
        ref_mem[1] = 32'h1234;
        ref_valid[1] = 1'b1;
        ref_err = 1'b0;
        chk(overwrite_err == ref_err, "err_same_entry", 64'(overwrite_err), 64'(ref_err));
        drain(2, 0);

        drain(0, 0);
        drain(20, 0);

        for (int a = 0; a < 8; a++) do_write(4'(a), 32'h5000 + 32'(a));
        model_push(8);
        d0 = n_done;
        drain_start = 1'b1;
        drain_count = 5'd8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_addr == 4'd2) found = 1'b1;
        end
        chk(found, "reached_entry2", 64'(found), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk(!out_valid && !busy, "rst_abort", 64'({out_valid, busy}), 64'(0));
        exp_q.delete();
        for (int a = 0; a < 16; a++) ref_valid[a] = 1'b0;
        ref_err = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(n_done == d0, "no_done_on_abort", 64'(n_done - d0), 64'(0));
        chk(overwrite_err == 1'b0, "err_after_rst", 64'(overwrite_err), 64'(0));
        drain(16, 0);

        do_write(4'd3, 32'h333);
        do_write(4'd9, 32'h999);
        drain(16, 1);

        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(0, 6);
            for (int j = 0; j < nw; j++) do_write(4'($urandom_range(0, 15)), $urandom);
            cnt = $urandom_range(0, 20);
            drain(cnt, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
